time_load_ctrl: RTL and testbench

TIME_LOAD_CTRL -- requirements
Module: time_load_ctrl

---
 rtl/time_load_pkg.sv | 31 +++
 rtl/time_load_ctrl_if.sv | 22 ++
 rtl/time_load_ctrl_rise_detect.sv | 27 ++
 rtl/time_load_ctrl.sv | 136 +++++++++++++
 tb/tb_time_load_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/time_load_pkg.sv
// Shared definitions for the time-load controller: FSM encoding, control and status bit layout.
package time_load_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StLoad  = 2'd2
    } state_e;

    localparam int unsigned CTRL_ARM_BIT       = 0;
    localparam int unsigned CTRL_DISARM_BIT    = 1;

    localparam int unsigned STAT_STATE_LSB     = 0;
    localparam int unsigned STAT_LOAD_DONE_BIT = 2;
    localparam int unsigned STAT_REARM_IGN_BIT = 3;
    localparam int unsigned STAT_CNT_LSB       = 16;

    function automatic logic [31:0] pack_status(input state_e     st,
                                                input logic       done,
                                                input logic       rearm,
                                                input logic [15:0] cnt);
        logic [31:0] w;
        w = '0;
        w[STAT_STATE_LSB +: 2]   = st;
        w[STAT_LOAD_DONE_BIT]    = done;
        w[STAT_REARM_IGN_BIT]    = rearm;
        w[STAT_CNT_LSB +: 16]    = cnt;
        return w;
    endfunction

endpackage

// File: rtl/time_load_ctrl_if.sv
// Software register and timestamp bundle between a host (master) and the time-load controller (slave).
interface time_load_ctrl_if;

    logic [31:0] ld_time_msw;
    logic [31:0] ld_time_lsw;
    logic [31:0] ctrl_word;
    logic        sync_in;
    logic [63:0] time_out;
    logic        load_pulse;
    logic [31:0] status_word;

    modport master (
        output ld_time_msw, ld_time_lsw, ctrl_word, sync_in,
        input  time_out, load_pulse, status_word
    );

    modport slave (
        input  ld_time_msw, ld_time_lsw, ctrl_word, sync_in,
        output time_out, load_pulse, status_word
    );

endinterface

// File: rtl/time_load_ctrl_rise_detect.sv
// Rising-edge detector; a level already high when reset releases is not reported as an edge.
module rise_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic prev_q;
    logic valid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            prev_q  <= d_i;
            valid_q <= 1'b1;
        end
    end

    // valid_q masks the first post-reset cycle, when prev_q has not seen the real input yet.
    always_comb begin
        rise_o = valid_q & d_i & ~prev_q;
    end

endmodule

// File: rtl/time_load_ctrl.sv
// Free-running 64-bit timestamp that is loaded from a software shadow on a qualified external sync.
module time_load_ctrl
    import time_load_pkg::*;
#(
    parameter int unsigned SYNC_SKIP = 0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             user_clk,
    input  logic             user_rst,
    time_load_ctrl_if.slave  bus
);

    localparam int unsigned SKIP_W = (SYNC_SKIP > 0) ? $clog2(SYNC_SKIP + 1) : 1;

    logic arm_edge;
    logic disarm_edge;
    logic sync_edge;

    state_e              state_q,      state_d;
    logic [63:0]         shadow_q,     shadow_d;
    logic [SKIP_W-1:0]   skip_cnt_q,   skip_cnt_d;
    logic                load_done_q,  load_done_d;
    logic                rearm_ign_q,  rearm_ign_d;
    logic [CNT_W-1:0]    load_count_q, load_count_d;
    logic [63:0]         time_q,       time_d;
    logic                load_pulse_q, load_pulse_d;
    logic [31:0]         status_q,     status_d;

    logic unused_ctrl;
    assign unused_ctrl = ^bus.ctrl_word[31:2];

    rise_detect u_arm_edge (
        .clk_i  (user_clk),
        .rst_i  (user_rst),
        .d_i    (bus.ctrl_word[CTRL_ARM_BIT]),
        .rise_o (arm_edge)
    );

    rise_detect u_disarm_edge (
        .clk_i  (user_clk),
        .rst_i  (user_rst),
        .d_i    (bus.ctrl_word[CTRL_DISARM_BIT]),
        .rise_o (disarm_edge)
    );

    rise_detect u_sync_edge (
        .clk_i  (user_clk),
        .rst_i  (user_rst),
        .d_i    (bus.sync_in),
        .rise_o (sync_edge)
    );

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        skip_cnt_d   = skip_cnt_q;
        load_done_d  = load_done_q;
        rearm_ign_d  = rearm_ign_q;
        load_count_d = load_count_q;
        time_d       = time_q + 64'd1;
        load_pulse_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A sync coinciding with the arm is deliberately not examined here.
                if (arm_edge) begin
                    shadow_d    = {bus.ld_time_msw, bus.ld_time_lsw};
                    skip_cnt_d  = SKIP_W'(SYNC_SKIP);
                    load_done_d = 1'b0;
                    rearm_ign_d = 1'b0;
                    state_d     = StArmed;
                end
            end
            StArmed: begin
                if (arm_edge) begin
                    rearm_ign_d = 1'b1;
                end
                if (disarm_edge) begin
                    state_d = StIdle;
                end else if (sync_edge) begin
                    if (skip_cnt_q == '0) begin
                        state_d = StLoad;
                    end else begin
                        skip_cnt_d = skip_cnt_q - SKIP_W'(1);
                    end
                end
            end
            StLoad: begin
                if (arm_edge) begin
                    rearm_ign_d = 1'b1;
                end
                time_d       = shadow_q;
                load_pulse_d = 1'b1;
                load_done_d  = 1'b1;
                if (load_count_q != '1) begin
                    load_count_d = load_count_q + CNT_W'(1);
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        status_d = pack_status(state_q, load_done_q, rearm_ign_q, 16'(load_count_q));
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q      <= StIdle;
            shadow_q     <= '0;
            skip_cnt_q   <= '0;
            load_done_q  <= 1'b0;
            rearm_ign_q  <= 1'b0;
            load_count_q <= '0;
            time_q       <= '0;
            load_pulse_q <= 1'b0;
            status_q     <= '0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            skip_cnt_q   <= skip_cnt_d;
            load_done_q  <= load_done_d;
            rearm_ign_q  <= rearm_ign_d;
            load_count_q <= load_count_d;
            time_q       <= time_d;
            load_pulse_q <= load_pulse_d;
            status_q     <= status_d;
        end
    end

    always_comb begin
        bus.time_out    = time_q;
        bus.load_pulse  = load_pulse_q;
        bus.status_word = status_q;
    end

endmodule

// File: tb/tb_time_load_ctrl.sv
// Directed bench for time_load_ctrl: two instances (no skip, skip of two) with a load-value scoreboard.
module tb_time_load_ctrl;
    import time_load_pkg::*;

    logic user_clk = 1'b0;
    logic user_rst;
    always #5 user_clk = ~user_clk;

    time_load_ctrl_if bus_a ();
    time_load_ctrl_if bus_b ();

    time_load_ctrl #(.SYNC_SKIP(0), .CNT_W(16)) dut_a (
        .user_clk (user_clk),
        .user_rst (user_rst),
        .bus      (bus_a)
    );

    time_load_ctrl #(.SYNC_SKIP(2), .CNT_W(16)) dut_b (
        .user_clk (user_clk),
        .user_rst (user_rst),
        .bus      (bus_b)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge user_clk);
        #1;
    endtask

    task automatic set_regs(input bit sel, input logic [31:0] msw, input logic [31:0] lsw);
        if (sel) begin
            bus_b.ld_time_msw = msw;
            bus_b.ld_time_lsw = lsw;
        end else begin
            bus_a.ld_time_msw = msw;
            bus_a.ld_time_lsw = lsw;
        end
    endtask

    task automatic set_ctrl(input bit sel, input logic [31:0] val);
        if (sel) bus_b.ctrl_word = val;
        else     bus_a.ctrl_word = val;
    endtask

    task automatic set_sync(input bit sel, input logic val);
        if (sel) bus_b.sync_in = val;
        else     bus_a.sync_in = val;
    endtask

    // Write load time, pulse the arm bit; the FSM is armed after the first step.
    task automatic arm(input bit sel, input logic [31:0] msw, input logic [31:0] lsw);
        set_regs(sel, msw, lsw);
        set_ctrl(sel, 32'h1);
        step();
        set_ctrl(sel, 32'h0);
        step();
    endtask

    task automatic pulse_sync(input bit sel);
        set_sync(sel, 1'b1);
        step();
        set_sync(sel, 1'b0);
    endtask

    // Called right after the edge that sampled a qualifying sync; the load lands one edge later.
    task automatic wait_load(input bit sel, input string tag);
        int lat;
        bit seen;
        logic [63:0] exp;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 8) begin
            step();
            lat++;
            seen = sel ? bus_b.load_pulse : bus_a.load_pulse;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        chk({tag, "_time"}, sel ? bus_b.time_out : bus_a.time_out, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] t0;

        user_rst = 1'b1;
        set_regs(1'b0, '0, '0);
        set_regs(1'b1, '0, '0);
        set_ctrl(1'b0, '0);
        set_ctrl(1'b1, '0);
        set_sync(1'b0, 1'b0);
        set_sync(1'b1, 1'b0);
        step(2);

        chk("rst_time_a",   bus_a.time_out, 64'd0);
        chk("rst_pulse_a",  64'(bus_a.load_pulse), 64'd0);
        chk("rst_status_a", 64'(bus_a.status_word), 64'd0);
        chk("rst_time_b",   bus_b.time_out, 64'd0);

        user_rst = 1'b0;
        step();
        chk("count_after_rst", bus_a.time_out, 64'd1);

        // Basic load with no skipping.
        arm(1'b0, 32'h0000_0001, 32'h0000_0010);
        exp_q.push_back(64'h0000_0001_0000_0010);
        chk("t1_armed_state", 64'(bus_a.status_word[1:0]), 64'(StArmed));
        pulse_sync(1'b0);
        wait_load(1'b0, "t1_load");
        step();
        chk("t1_pulse_one_cycle", 64'(bus_a.load_pulse), 64'd0);
        chk("t1_time_incr", bus_a.time_out, 64'h0000_0001_0000_0011);
        chk("t1_status", 64'(bus_a.status_word), 64'h0001_0004);

        // Skip of two: first pulse held high several cycles counts once.
        arm(1'b1, 32'hDEAD_BEEF, 32'h0123_4567);
        exp_q.push_back(64'hDEAD_BEEF_0123_4567);
        chk("t2_skip_2", 64'(dut_b.skip_cnt_q), 64'd2);
        set_sync(1'b1, 1'b1);
        step(3);
        set_sync(1'b1, 1'b0);
        step();
        chk("t2_skip_1", 64'(dut_b.skip_cnt_q), 64'd1);
        chk("t2_no_pulse_1", 64'(bus_b.load_pulse), 64'd0);
        pulse_sync(1'b1);
        step();
        chk("t2_skip_0", 64'(dut_b.skip_cnt_q), 64'd0);
        chk("t2_still_armed", 64'(bus_b.status_word[1:0]), 64'(StArmed));
        pulse_sync(1'b1);
        wait_load(1'b1, "t2_load");

        // Disarm coinciding with sync wins.
        arm(1'b0, 32'hAAAA_AAAA, 32'h5555_5555);
        chk("t3_armed_state", 64'(bus_a.status_word[1:0]), 64'(StArmed));
        set_ctrl(1'b0, 32'h2);
        set_sync(1'b0, 1'b1);
        step();
        set_ctrl(1'b0, 32'h0);
        set_sync(1'b0, 1'b0);
        t0 = bus_a.time_out;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_no_pulse", 64'(bus_a.load_pulse), 64'd0);
        end
        chk("t3_time_runs", bus_a.time_out, t0 + 64'd4);
        chk("t3_idle_state", 64'(bus_a.status_word[1:0]), 64'(StIdle));

        // Re-arm while armed is ignored; original shadow loads.
        arm(1'b0, 32'h1111_2222, 32'h3333_4444);
        exp_q.push_back(64'h1111_2222_3333_4444);
        arm(1'b0, 32'h5555_6666, 32'h7777_8888);
        pulse_sync(1'b0);
        wait_load(1'b0, "t4_load");
        step();
        chk("t4_status", 64'(bus_a.status_word), 64'h0002_000C);

        // Wrap through 2^64-1.
        arm(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
        pulse_sync(1'b0);
        wait_load(1'b0, "t5_load");
        step();
        chk("t5_time_max", bus_a.time_out, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        chk("t5_time_wrap", bus_a.time_out, 64'd0);
        chk("t5_status", 64'(bus_a.status_word), 64'h0003_0004);

        // Reset while armed abandons the load; a held arm bit does not re-arm.
        set_regs(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
        set_ctrl(1'b0, 32'h1);
        step(2);
        chk("t6_armed_state", 64'(bus_a.status_word[1:0]), 64'(StArmed));
        user_rst = 1'b1;
        step();
        chk("t6_rst_time",   bus_a.time_out, 64'd0);
        chk("t6_rst_pulse",  64'(bus_a.load_pulse), 64'd0);
        chk("t6_rst_status", 64'(bus_a.status_word), 64'd0);
        user_rst = 1'b0;
        set_sync(1'b0, 1'b1);
        step();
        set_sync(1'b0, 1'b0);
        chk("t6_time_after_rst", bus_a.time_out, 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_no_pulse", 64'(bus_a.load_pulse), 64'd0);
        end
        pulse_sync(1'b0);
        step(2);
        chk("t6_no_pulse_late", 64'(bus_a.load_pulse), 64'd0);
        chk("t6_status_idle", 64'(bus_a.status_word), 64'd0);
        set_ctrl(1'b0, 32'h0);
        step();
        arm(1'b0, 32'h0BAD_F00D, 32'hCAFE_0001);
        exp_q.push_back(64'h0BAD_F00D_CAFE_0001);
        chk("t6_rearm_state", 64'(bus_a.status_word[1:0]), 64'(StArmed));
        pulse_sync(1'b0);
        wait_load(1'b0, "t6_load");
        step();
        chk("t6_status", 64'(bus_a.status_word), 64'h0001_0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
